// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV32M-style multiply/divide unit, XLEN-generic.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a
// single 2*XLEN product/remainder:quotient register shared by both operations.
module cpu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // product / quotient sign
  logic              rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [PW-1:0]     prod_q, prod_d;   // product, or {remainder, quotient}
  logic [XLEN-1:0]   result_q, result_d;
  logic              start_ready_q, result_valid_q, busy_q;

  // Operand decode at the accept edge
  logic            accept;
  logic            is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    accept   = start_valid && (state_q == S_IDLE);
    is_div   = op[2];
    a_signed = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa       = a_signed && src_a[XLEN-1];
    sb       = b_signed && src_b[XLEN-1];
    mag_a    = sa ? (~src_a + XLEN'(1)) : src_a;
    mag_b    = sb ? (~src_b + XLEN'(1)) : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (src_a == MIN_NEG) && (src_b == '1);
    fast     = div_zero || div_ovf;
    // op[1] selects REM/REMU among the divide ops
    if (div_zero) begin
      fast_res = op[1] ? src_a : '1;
    end else begin
      fast_res = op[1] ? '0 : src_a;
    end
  end

  // One iteration step for each operation, plus the final sign fixup
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;
  logic [XLEN+1:0] div_diff;
  logic [PW-1:0]   div_next;
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_res;

  always_comb begin
    mul_sum  = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[XLEN-1:1]};
    div_diff = {1'b0, prod_q[PW-1:XLEN], prod_q[XLEN-1]} - {2'b00, opnd_q};
    div_next = div_diff[XLEN+1] ? {prod_q[PW-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    prod_s   = neg_q  ? (~prod_q + PW'(1)) : prod_q;
    quo_s    = neg_q  ? (~prod_q[XLEN-1:0] + XLEN'(1)) : prod_q[XLEN-1:0];
    rem_s    = rneg_q ? (~prod_q[PW-1:XLEN] + XLEN'(1)) : prod_q[PW-1:XLEN];
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_s : quo_s;
    end else begin
      fix_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    end
  end

  // State register and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_ready_q  <= (state_d == S_IDLE);
      result_valid_q <= (state_d == S_DONE);
      busy_q         <= (state_d != S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(XLEN)) state_d = S_DONE;
      S_DONE: if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, iteration, fixup/result write
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          op_d   = op;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          if (is_div) begin
            opnd_d = mag_b;
            prod_d = {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            prod_d = {{XLEN{1'b0}}, mag_b};
          end
          if (fast) result_d = fast_res;
        end
      end
      S_CALC: begin
        if (cnt_q != CNT_W'(XLEN)) begin
          prod_d = op_q[2] ? div_next : mul_next;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          result_d = fix_res;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign result       = result_q;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Directed bench for cpu_muldiv at XLEN=32 and XLEN=8.
module tb_cpu_muldiv;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk, rst;
  int   checks, failures;

  logic        sv32, sr32, rv32, rr32, busy32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        sv8, sr8, rv8, rr8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  cpu_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .start_valid(sv32), .start_ready(sr32), .op(op32),
    .src_a(a32), .src_b(b32),
    .result_valid(rv32), .result_ready(rr32), .result(res32), .busy(busy32)
  );

  cpu_muldiv #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8), .op(op8),
    .src_a(a8), .src_b(b8),
    .result_valid(rv8), .result_ready(rr8), .result(res8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency = edges after the accept edge until result_valid is seen high
  task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    int n;
    n = 0;
    while (!sr32 && n < 100) begin @(posedge clk); #1; n++; end
    op32 = o; a32 = a; b32 = b; sv32 = 1'b1; rr32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
    n = 0;
    while (!rv32 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, 64'(res32), 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'(sr32), 64'd1);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int lat, input string tag);
    int n;
    n = 0;
    while (!sr8 && n < 100) begin @(posedge clk); #1; n++; end
    op8 = o; a8 = a; b8 = b; sv8 = 1'b1; rr8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
    n = 0;
    while (!rv8 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, 64'(res8), 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'(sr8), 64'd1);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1;
    sv32 = 1'b0; rr32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
    sv8  = 1'b0; rr8  = 1'b1; op8  = '0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", 64'(sr32), 64'd1);
    chk("rst_result_valid", 64'(rv32), 64'd0);
    chk("rst_result", 64'(res32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst8_start_ready", 64'(sr8), 64'd1);
    rst = 1'b0;

    // Normal path: XLEN+1 edges; fast path: DONE entered on the accept edge
    run32(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run32(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run32(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run32(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run32(OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
    run32(OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
    run32(OP_DIVU,   32'd100,      32'd7,        32'd14,        33, "divu");
    run32(OP_REMU,   32'd100,      32'd7,        32'd2,         33, "remu");
    run32(OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 0,  "divu_by0");
    run32(OP_REM,    32'd5,        32'd0,        32'd5,         0,  "rem_by0");
    run32(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run32(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0, "rem_ovf");

    // Backpressure: result held, no new accept while DONE
    rr32 = 1'b0; op32 = OP_MUL; a32 = 32'd7; b32 = 32'hFFFF_FFFD; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    n = 0;
    while (!rv32 && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_lat", 64'(n), 64'd33);
    for (int i = 0; i < 10; i++) begin
      a32 = $urandom; b32 = $urandom; op32 = 3'($urandom); sv32 = i[0];
      @(posedge clk); #1;
      chk("bp_result", 64'(res32), 64'hFFFF_FFEB);
      chk("bp_start_ready", 64'(sr32), 64'd0);
      chk("bp_result_valid", 64'(rv32), 64'd1);
    end
    sv32 = 1'b0; rr32 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(sr32), 64'd1);
    chk("bp_release_valid", 64'(rv32), 64'd0);
    @(posedge clk); #1;
    chk("bp_no_reaccept", 64'(busy32), 64'd0);

    // Reset with the counter at 12 during a DIV
    op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7; sv32 = 1'b1;
    @(posedge clk); #1;
    sv32 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy32), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_start_ready", 64'(sr32), 64'd1);
    chk("mid_rst_result_valid", 64'(rv32), 64'd0);
    chk("mid_rst_result", 64'(res32), 64'd0);
    run32(OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul_after_rst");

    // XLEN=8
    run8(OP_MUL,    8'd7,   8'hFD, 8'hEB, 9, "mul8");
    run8(OP_MULH,   8'h80,  8'h80, 8'h40, 9, "mulh8");
    run8(OP_MULHSU, 8'hFF,  8'hFF, 8'hFF, 9, "mulhsu8");
    run8(OP_MULHU,  8'hFF,  8'hFF, 8'hFE, 9, "mulhu8");
    run8(OP_DIV,    8'hF9,  8'd2,  8'hFD, 9, "div8");
    run8(OP_REM,    8'hF9,  8'd2,  8'hFF, 9, "rem8");
    run8(OP_DIVU,   8'd100, 8'd7,  8'd14, 9, "divu8");
    run8(OP_REMU,   8'd100, 8'd7,  8'd2,  9, "remu8");
    run8(OP_DIVU,   8'd5,   8'd0,  8'hFF, 0, "divu8_by0");
    run8(OP_REM,    8'd5,   8'd0,  8'd5,  0, "rem8_by0");
    run8(OP_DIV,    8'h80,  8'hFF, 8'h80, 0, "div8_ovf");
    run8(OP_REM,    8'h80,  8'hFF, 8'h00, 0, "rem8_ovf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
